// File: rtl/pipe_stage_pkg.sv
// ============================================================================
// Module      : pipe_stage_pkg
// Description : Shared occupancy encoding and counter width for pipe_stage_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_stage_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_occ_t;

  localparam int unsigned PS_CNT_W = 32;

endpackage : pipe_stage_pkg

`default_nettype wire

// File: rtl/pipe_stage_slot.sv
// ============================================================================
// Module      : pipe_stage_slot
// Description : One valid+data register with load, clear-to-NOP and hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Clear wins over load so a flush always leaves a clean bubble behind.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VALUE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : pipe_stage_slot

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Pipeline latch with valid/ready, en qualifier, flush and a
//               2-entry skid buffer. Optional stats: PIPE_STAGE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [PS_CNT_W-1:0] stall_cnt,
  output logic [PS_CNT_W-1:0] flush_cnt
`endif
);

  pipe_occ_t        r_state;
  pipe_occ_t        w_next_state;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_load;
  logic             w_main_clear;
  logic             w_main_from_skid;
  logic             w_skid_load;
  logic             w_skid_clear;

  logic [WIDTH-1:0] w_main_din;
  logic             w_main_valid;
  logic [WIDTH-1:0] w_main_data;
  logic             w_skid_valid;
  logic [WIDTH-1:0] w_skid_data;

  // in_ready comes straight from the skid valid flop, so downstream
  // backpressure never reaches upstream combinationally.
  assign in_ready   = ~w_skid_valid;
  assign w_in_fire  = in_valid & in_ready & en;
  assign w_out_fire = w_main_valid & out_ready & en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= PS_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;

    if (en) begin
      if (flush) begin
        w_next_state = PS_EMPTY;
        w_main_clear = 1'b1;
        w_skid_clear = 1'b1;
      end else begin
        case (r_state)
          PS_EMPTY: begin
            if (w_in_fire) begin
              w_main_load  = 1'b1;
              w_next_state = PS_ONE;
            end
          end
          PS_ONE: begin
            if (w_out_fire && w_in_fire) begin
              w_main_load = 1'b1;
            end else if (w_out_fire) begin
              w_main_clear = 1'b1;
              w_next_state = PS_EMPTY;
            end else if (w_in_fire) begin
              w_skid_load  = 1'b1;
              w_next_state = PS_TWO;
            end
          end
          PS_TWO: begin
            // Skid promotes to main; in_fire is impossible here.
            if (w_out_fire) begin
              w_main_load      = 1'b1;
              w_main_from_skid = 1'b1;
              w_skid_clear     = 1'b1;
              w_next_state     = PS_ONE;
            end
          end
          default: begin
            w_next_state = PS_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
          end
        endcase
      end
    end
  end

  assign w_main_din = w_main_from_skid ? w_skid_data : in_data;

  pipe_stage_slot #(
    .WIDTH     (WIDTH),
    .NOP_VALUE (NOP_VALUE)
  ) u_main (
    .clk     (CLK),
    .rst     (RST),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  pipe_stage_slot #(
    .WIDTH     (WIDTH),
    .NOP_VALUE (NOP_VALUE)
  ) u_skid (
    .clk     (CLK),
    .rst     (RST),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;

`ifdef PIPE_STAGE_STATS_EN
  logic [PS_CNT_W-1:0] r_stall_cnt;
  logic [PS_CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_main_valid && !out_ready && en) begin
        r_stall_cnt <= r_stall_cnt + PS_CNT_W'(1);
      end
      if (flush && en) begin
        r_flush_cnt <= r_flush_cnt + PS_CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule : pipe_stage_reg

`default_nettype wire
